// File: rtl/memory_access.sv
// MEM stage: 24-bit loads/stores serialised as three byte transfers (LSB first) over a req/ack byte port.
// Latency: 1 cycle for non-memory ops; 4 edges from acceptance for a zero-wait memory op, +1 per ack wait state.
// Backpressure: stall freezes upstream while a word is in flight; it drops in the final-ack cycle.
//
// Ports:
//   clk, rst (sync, active-low)           clock / reset
//   en, valid_in, aluOut, writeData,      EX/MEM fields
//   memWrite, memToReg, regWrite, Rd
//   mem_req/mem_we/mem_addr/mem_wdata     byte request to data memory (registered)
//   mem_rdata/mem_ack                     byte response
//   stall                                 upstream freeze
//   bufferOut                             MEM/WB buffer {valid, readData, aluOut, memToReg, regWrite, Rd}
module memory_access #(
    parameter int RW     = 24,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              valid_in,
    input  logic [RW-1:0]     aluOut,
    input  logic [RW-1:0]     writeData,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic              regWrite,
    input  logic [3:0]        Rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic [54:0]       bufferOut
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic [RW-1:0]       alu_q;
    logic [RW-1:0]       wdata_q;
    logic [RW-1:0]       rdata_q;
    logic                store_q;
    logic                to_reg_q;
    logic                reg_write_q;
    logic [3:0]          rd_q;
    logic                req_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wbyte_q;
    logic [54:0]         buf_q;

    logic                mem_op;
    logic [RW-1:0]       rdata_d;
    logic [7:0]          wbyte_d;

    assign mem_op = valid_in & (memWrite | memToReg);

    // Merge the incoming byte into its little-endian lane; stores never touch
    // readData so it stays zero for them.
    always_comb begin
        rdata_d = rdata_q;
        if (!store_q) begin
            case (cnt_q)
                2'd0:    rdata_d[7:0]   = mem_rdata;
                2'd1:    rdata_d[15:8]  = mem_rdata;
                default: rdata_d[23:16] = mem_rdata;
            endcase
        end
    end

    // Byte to present after the current one is acknowledged.
    always_comb begin
        case (cnt_q)
            2'd0:    wbyte_d = wdata_q[15:8];
            default: wbyte_d = wdata_q[23:16];
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (rst) begin
            if (state_q == IDLE) stall = en & mem_op;
            else                 stall = ~((cnt_q == 2'd2) & mem_ack);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            alu_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            store_q     <= 1'b0;
            to_reg_q    <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 4'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wbyte_q     <= 8'd0;
            buf_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        if (mem_op) begin
                            state_q     <= ACCESS;
                            cnt_q       <= 2'd0;
                            alu_q       <= aluOut;
                            wdata_q     <= writeData;
                            rdata_q     <= '0;
                            store_q     <= memWrite;   // store wins over load
                            to_reg_q    <= memToReg;
                            reg_write_q <= regWrite;
                            rd_q        <= Rd;
                            req_q       <= 1'b1;
                            we_q        <= memWrite;
                            addr_q      <= aluOut[ADDR_W-1:0];
                            wbyte_q     <= writeData[7:0];
                            buf_q       <= '0;         // bubble while the word is in flight
                        end else begin
                            buf_q <= {valid_in, {RW{1'b0}}, aluOut, memToReg, regWrite, Rd};
                        end
                    end
                end
                ACCESS: begin
                    // Request fields only move on ack, so they hold through wait states.
                    if (mem_ack) begin
                        rdata_q <= rdata_d;
                        if (cnt_q == 2'd2) begin
                            state_q <= IDLE;
                            cnt_q   <= 2'd0;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            addr_q  <= '0;
                            wbyte_q <= 8'd0;
                            buf_q   <= {1'b1, rdata_d, alu_q, to_reg_q, reg_write_q, rd_q};
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                            addr_q  <= addr_q + 1'b1;  // wraps modulo 2^ADDR_W
                            wbyte_q <= wbyte_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wbyte_q;
    assign bufferOut = buf_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic [23:0] aluOut;
    logic [23:0] writeData;
    logic        memWrite;
    logic        memToReg;
    logic        regWrite;
    logic [3:0]  Rd;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [54:0] bufferOut;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:16383];
    int wait_cfg = 0;
    int wcnt = 0;

    always #5 clk = ~clk;

    memory_access #(.RW(24), .ADDR_W(14)) dut (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in),
        .aluOut(aluOut), .writeData(writeData), .memWrite(memWrite),
        .memToReg(memToReg), .regWrite(regWrite), .Rd(Rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .bufferOut(bufferOut)
    );

    // Byte-wide memory: decides ack for the coming edge half a cycle early,
    // inserting wait_cfg wait states before each ack.
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (wcnt >= wait_cfg) begin
                mem_ack = 1'b1;
                wcnt    = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        mem_rdata = mem[mem_addr];
        if (mem_ack && mem_we) mem[mem_addr] = mem_wdata;
    end

    function automatic logic [54:0] mkbuf(input logic v, input logic [23:0] rdat,
                                          input logic [23:0] alu, input logic m2r,
                                          input logic rw, input logic [3:0] r);
        return {v, rdat, alu, m2r, rw, r};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; valid_in = 1'b0; aluOut = '0; writeData = '0;
        memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0; Rd = 4'd0;
    endtask

    task automatic start_load(input logic [23:0] a, input logic [3:0] r);
        en = 1'b1; valid_in = 1'b1; aluOut = a; memToReg = 1'b1; memWrite = 1'b0;
        regWrite = 1'b1; Rd = r;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; valid_in = 1'b1; memToReg = 1'b1; aluOut = 24'h123456;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall_comb: got %b want 0", stall); end
        step();
        checks++; if (bufferOut !== 55'd0) begin errors++; $display("FAIL rst_buf: got %h want 0", bufferOut); end
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_req_we: got %b want 00", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 14'd0 || mem_wdata !== 8'd0) begin errors++; $display("FAIL rst_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        rst = 1'b1; idle_inputs();
        step();
    endtask

    task automatic test_alu_pass();
        en = 1'b1; valid_in = 1'b1; aluOut = 24'h00ABCD; regWrite = 1'b1; Rd = 4'd5;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
        step();
        checks++; if (bufferOut !== mkbuf(1'b1, 24'h0, 24'h00ABCD, 1'b0, 1'b1, 4'd5)) begin errors++; $display("FAIL alu_buf: got %h want %h", bufferOut, mkbuf(1'b1, 24'h0, 24'h00ABCD, 1'b0, 1'b1, 4'd5)); end
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL alu_no_access: got stall=%b req=%b want 0/0", stall, mem_req); end
        idle_inputs();
        step();
    endtask

    task automatic test_zero_wait_load();
        wait_cfg = 0;
        mem[16'h10] = 8'hAB; mem[16'h11] = 8'hCD; mem[16'h12] = 8'hEF;
        start_load(24'h000010, 4'd3);
        #1;
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL zw_accept: got stall=%b req=%b want 1/0", stall, mem_req); end
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_addr !== 14'h10 + 14'(i) || mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL zw_addr%0d: got addr=%h req=%b we=%b want %h/1/0", i, mem_addr, mem_req, mem_we, 14'h10 + 14'(i)); end
            checks++; if (stall !== (i < 2) || bufferOut[54] !== 1'b0) begin errors++; $display("FAIL zw_stall%0d: got stall=%b valid=%b want %b/0", i, stall, bufferOut[54], (i < 2)); end
            step();
        end
        checks++; if (bufferOut !== mkbuf(1'b1, 24'hEFCDAB, 24'h000010, 1'b1, 1'b1, 4'd3)) begin errors++; $display("FAIL zw_buf: got %h want %h", bufferOut, mkbuf(1'b1, 24'hEFCDAB, 24'h000010, 1'b1, 1'b1, 4'd3)); end
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL zw_done: got req=%b stall=%b want 0/0", mem_req, stall); end
        step();
    endtask

    task automatic test_store_waits();
        logic [7:0] sb [3];
        sb[0] = 8'h56; sb[1] = 8'h34; sb[2] = 8'h12;
        wait_cfg = 2;
        mem[16'h20] = 8'h00; mem[16'h21] = 8'h00; mem[16'h22] = 8'h00;
        en = 1'b1; valid_in = 1'b1; memWrite = 1'b1; memToReg = 1'b0;
        writeData = 24'h123456; aluOut = 24'h000020; regWrite = 1'b0; Rd = 4'd7;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st_accept: got stall=%b want 1", stall); end
        step();
        idle_inputs();
        for (int c = 0; c < 9; c++) begin
            checks++; if (mem_addr !== 14'h20 + 14'(c / 3) || mem_wdata !== sb[c / 3] || mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL st_req%0d: got addr=%h wdata=%h we=%b req=%b want %h/%h/1/1", c, mem_addr, mem_wdata, mem_we, mem_req, 14'h20 + 14'(c / 3), sb[c / 3]); end
            checks++; if (stall !== (c != 8)) begin errors++; $display("FAIL st_stall%0d: got %b want %b", c, stall, (c != 8)); end
            step();
        end
        checks++; if (bufferOut !== mkbuf(1'b1, 24'h0, 24'h000020, 1'b0, 1'b0, 4'd7)) begin errors++; $display("FAIL st_buf: got %h want %h", bufferOut, mkbuf(1'b1, 24'h0, 24'h000020, 1'b0, 1'b0, 4'd7)); end
        checks++; if ({mem[16'h22], mem[16'h21], mem[16'h20]} !== 24'h123456) begin errors++; $display("FAIL st_mem: got %h%h%h want 123456", mem[16'h22], mem[16'h21], mem[16'h20]); end
        wait_cfg = 0;
        step();
    endtask

    task automatic test_wrap();
        logic [13:0] ea [3];
        ea[0] = 14'h3FFF; ea[1] = 14'h0000; ea[2] = 14'h0001;
        mem[16'h3FFF] = 8'h11; mem[16'h0000] = 8'h22; mem[16'h0001] = 8'h33;
        start_load(24'hFF3FFF, 4'd9);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_addr !== ea[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, mem_addr, ea[i]); end
            step();
        end
        checks++; if (bufferOut !== mkbuf(1'b1, 24'h332211, 24'hFF3FFF, 1'b1, 1'b1, 4'd9)) begin errors++; $display("FAIL wrap_buf: got %h want %h", bufferOut, mkbuf(1'b1, 24'h332211, 24'hFF3FFF, 1'b1, 1'b1, 4'd9)); end
        step();
    endtask

    task automatic test_reset_mid();
        start_load(24'h000010, 4'd4);
        step();
        idle_inputs();
        step();                     // first byte acked, now on byte 1
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_comb: got %b want 0", stall); end
        step();
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || bufferOut !== 55'd0) begin errors++; $display("FAIL rmid_state: got req=%b stall=%b buf=%h want 0/0/0", mem_req, stall, bufferOut); end
        rst = 1'b1;
        step();
        start_load(24'h000010, 4'd4);
        step();
        idle_inputs();
        step(); step(); step();
        checks++; if (bufferOut !== mkbuf(1'b1, 24'hEFCDAB, 24'h000010, 1'b1, 1'b1, 4'd4)) begin errors++; $display("FAIL rmid_fresh: got %h want %h", bufferOut, mkbuf(1'b1, 24'hEFCDAB, 24'h000010, 1'b1, 1'b1, 4'd4)); end
        step();
    endtask

    task automatic test_en_low();
        logic [54:0] hold;
        hold = mkbuf(1'b1, 24'h0, 24'h000777, 1'b0, 1'b1, 4'd2);
        mem[16'h13] = 8'h5A;
        en = 1'b1; valid_in = 1'b1; aluOut = 24'h000777; regWrite = 1'b1; Rd = 4'd2;
        step();
        start_load(24'h000011, 4'd6);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL enl_stall%0d: got %b want 0", i, stall); end
            step();
            checks++; if (mem_req !== 1'b0 || bufferOut !== hold) begin errors++; $display("FAIL enl_hold%0d: got req=%b buf=%h want 0/%h", i, mem_req, bufferOut, hold); end
        end
        en = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL enl_start_stall: got %b want 1", stall); end
        step();
        idle_inputs();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h11) begin errors++; $display("FAIL enl_req: got req=%b addr=%h want 1/0011", mem_req, mem_addr); end
        step(); step(); step();
        checks++; if (bufferOut !== mkbuf(1'b1, 24'h5AEFCD, 24'h000011, 1'b1, 1'b1, 4'd6)) begin errors++; $display("FAIL enl_buf: got %h want %h", bufferOut, mkbuf(1'b1, 24'h5AEFCD, 24'h000011, 1'b1, 1'b1, 4'd6)); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        rst = 1'b0;
        idle_inputs();
        step();
        test_reset();
        test_alu_pass();
        test_zero_wait_load();
        test_store_waits();
        test_wrap();
        test_reset_mid();
        test_en_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
